// File: rtl/scan_pkg.sv
// Shared types and widths for the row scan sequencer.
package scan_pkg;
  localparam int unsigned ROW_W   = 4;
  localparam int unsigned BLANK_W = 8;

  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_e;
endpackage

// File: rtl/scan_timer.sv
// Loadable down-counter; expired flags the final cycle of a loaded phase.
module scan_timer #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         expired
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == W'(1));

endmodule

// File: rtl/row_scan_ctrl.sv
// Row sequencer for a 4-to-16 decoder: per row a blanking gap, then a dwell with enable high.
module row_scan_ctrl
  import scan_pkg::*;
#(
  parameter int unsigned NUM_ROWS = 16,
  parameter int unsigned DWELL_W  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               continuous,
  input  logic [DWELL_W-1:0] dwell_cycles,
  input  logic [BLANK_W-1:0] blank_cycles,
  output logic               enable_out,
  output logic [ROW_W-1:0]   binary_out,
  output logic               row_start,
  output logic               frame_done,
  output logic               busy
);

  localparam int unsigned TW = (DWELL_W > BLANK_W) ? DWELL_W : BLANK_W;
  localparam logic [ROW_W-1:0] LastRow = ROW_W'(NUM_ROWS - 1);

  state_e             state_q, state_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [DWELL_W-1:0] dwell_q, dwell_eff;
  logic [BLANK_W-1:0] blank_q;
  logic               cont_q, stop_pend_q;

  logic               load, expired;
  logic [TW-1:0]      load_val, count, cnt_next;
  logic               start_go, blank_end, drive_end, next_row, go_idle, enter_drive;
  logic               fd_next;

  scan_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .expired  (expired)
  );

  always_comb begin
    dwell_eff   = (dwell_cycles == '0) ? DWELL_W'(1) : dwell_cycles;
    start_go    = (state_q == IDLE) && start;
    blank_end   = (state_q == BLANK) && expired;
    drive_end   = (state_q == DRIVE) && expired;
    // A stop arriving on the final dwell cycle still ends the scan at this boundary.
    next_row    = drive_end && !(stop_pend_q || stop) && ((row_q != LastRow) || cont_q);
    go_idle     = drive_end && !next_row;
    load        = 1'b0;
    load_val    = '0;
    state_d     = state_q;
    row_d       = row_q;
    enter_drive = 1'b0;

    if (start_go) begin
      load  = 1'b1;
      row_d = '0;
      if (blank_cycles != '0) begin
        load_val = TW'(blank_cycles);
        state_d  = BLANK;
      end else begin
        load_val    = TW'(dwell_eff);
        state_d     = DRIVE;
        enter_drive = 1'b1;
      end
    end else if (blank_end) begin
      load        = 1'b1;
      load_val    = TW'(dwell_q);
      state_d     = DRIVE;
      enter_drive = 1'b1;
    end else if (next_row) begin
      load  = 1'b1;
      row_d = (row_q == LastRow) ? '0 : row_q + 1'b1;
      if (blank_q != '0) begin
        load_val = TW'(blank_q);
        state_d  = BLANK;
      end else begin
        load_val    = TW'(dwell_q);
        state_d     = DRIVE;
        enter_drive = 1'b1;
      end
    end else if (go_idle) begin
      state_d = IDLE;
      row_d   = '0;
    end

    // Registered frame_done needs a one-cycle lookahead onto the last dwell cycle.
    cnt_next = load ? load_val : ((count != '0) ? count - 1'b1 : count);
    fd_next  = (state_d == DRIVE) && (row_d == LastRow) && (cnt_next == TW'(1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      row_q       <= '0;
      dwell_q     <= '0;
      blank_q     <= '0;
      cont_q      <= 1'b0;
      stop_pend_q <= 1'b0;
      enable_out  <= 1'b0;
      binary_out  <= '0;
      row_start   <= 1'b0;
      frame_done  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      enable_out <= (state_d == DRIVE);
      binary_out <= row_d;
      row_start  <= enter_drive;
      frame_done <= fd_next;
      busy       <= (state_d != IDLE);
      if (start_go) begin
        dwell_q <= dwell_eff;
        blank_q <= blank_cycles;
        cont_q  <= continuous;
      end
      if (go_idle) begin
        stop_pend_q <= 1'b0;
      end else if (stop && (state_q != IDLE)) begin
        stop_pend_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_row_scan_ctrl.sv
// Scoreboard bench: per-cycle expected outputs are queued from the scan timing rules.
module tb_row_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, stop, continuous;
  logic        start4, start16;
  logic [15:0] dwell_cycles;
  logic [7:0]  blank_cycles;

  logic       en4, rs4, fd4, busy4, en16, rs16, fd16, busy16;
  logic [3:0] bin4, bin16;

  logic use16;
  logic [7:0] obs;

  typedef struct packed {
    logic [7:0] exp;  // {enable, binary[3:0], row_start, frame_done, busy}
    logic       stop;
    logic       poke;
    logic       rst;
  } ent_t;

  ent_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  row_scan_ctrl #(.NUM_ROWS(4), .DWELL_W(16)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .stop(stop), .continuous(continuous),
    .dwell_cycles(dwell_cycles), .blank_cycles(blank_cycles),
    .enable_out(en4), .binary_out(bin4), .row_start(rs4), .frame_done(fd4), .busy(busy4)
  );

  row_scan_ctrl #(.NUM_ROWS(16), .DWELL_W(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .stop(stop), .continuous(continuous),
    .dwell_cycles(dwell_cycles), .blank_cycles(blank_cycles),
    .enable_out(en16), .binary_out(bin16), .row_start(rs16), .frame_done(fd16), .busy(busy16)
  );

  always_comb begin
    obs = use16 ? {en16, bin16, rs16, fd16, busy16} : {en4, bin4, rs4, fd4, busy4};
  end

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got en/bin/rs/fd/busy=%b, want %b", tag, got, want);
    end
  endtask

  function automatic void push_e(logic en, int bin, logic rs, logic fd, logic bsy);
    ent_t e;
    e = '0;
    e.exp = {en, 4'(bin), rs, fd, bsy};
    q.push_back(e);
  endfunction

  function automatic void push_rows(int n, int r0, int r1, int b, int d);
    for (int r = r0; r <= r1; r++) begin
      for (int k = 0; k < b; k++) push_e(1'b0, r, 1'b0, 1'b0, 1'b1);
      for (int k = 0; k < d; k++) push_e(1'b1, r, k == 0, (k == d - 1) && (r == n - 1), 1'b1);
    end
  endfunction

  function automatic void push_idle(int n);
    for (int k = 0; k < n; k++) push_e(1'b0, 0, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic void set_flag(int idx, int which);
    ent_t e;
    e = q[idx];
    if (which == 0) e.stop = 1'b1;
    else if (which == 1) e.poke = 1'b1;
    else e.rst = 1'b1;
    q[idx] = e;
  endfunction

  task automatic pulse_start();
    if (use16) start16 = 1'b1;
    else start4 = 1'b1;
    @(posedge clk);
    #1;
    start4  = 1'b0;
    start16 = 1'b0;
  endtask

  // Compares one queued entry per cycle; the entry's flags drive inputs for that same cycle.
  task automatic drain(input string name);
    ent_t e;
    int   i = 0;
    while (q.size() > 0) begin
      if (i != 0) begin
        @(posedge clk);
        #1;
      end
      e = q.pop_front();
      check_eq($sformatf("%s[%0d]", name, i), obs, e.exp);
      stop    = e.stop;
      rst_n   = !e.rst;
      start4  = e.poke && !use16;
      start16 = e.poke && use16;
      if (e.poke) begin
        dwell_cycles = 16'd7;
        blank_cycles = 8'd5;
        continuous   = 1'b1;
      end
      i++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; stop = 1'b0; continuous = 1'b0; start4 = 1'b0; start16 = 1'b0;
    dwell_cycles = '0; blank_cycles = '0; use16 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    push_idle(1); drain("rst4");
    use16 = 1'b1;
    push_idle(1); drain("rst16");

    // Single 4-row frame: 2 blank + 3 dwell per row, frame_done at t+20.
    use16 = 1'b0; dwell_cycles = 16'd3; blank_cycles = 8'd2; continuous = 1'b0;
    pulse_start();
    push_rows(4, 0, 3, 2, 3); push_idle(2);
    drain("frame4");

    // Zero blank, zero dwell: one row per cycle, enable held high.
    use16 = 1'b1; dwell_cycles = 16'd0; blank_cycles = 8'd0;
    pulse_start();
    push_rows(16, 0, 15, 0, 1); push_idle(2);
    drain("fast16");

    // Continuous with wrap, then stop in blank of row 5 of the third frame; stop in idle ignored.
    dwell_cycles = 16'd2; blank_cycles = 8'd1; continuous = 1'b1;
    pulse_start();
    push_rows(16, 0, 15, 1, 2); push_rows(16, 0, 15, 1, 2); push_rows(16, 0, 5, 1, 2);
    push_idle(3);
    set_flag(111, 0);
    set_flag(115, 0);
    drain("cont16");

    dwell_cycles = 16'd1; blank_cycles = 8'd0; continuous = 1'b0;
    pulse_start();
    push_rows(16, 0, 15, 0, 1); push_idle(1);
    drain("restart16");

    // Start and config changes while busy must not disturb the latched frame.
    use16 = 1'b0; dwell_cycles = 16'd3; blank_cycles = 8'd2; continuous = 1'b0;
    pulse_start();
    push_rows(4, 0, 3, 2, 3); push_idle(2);
    set_flag(7, 1);
    drain("busy4");

    // Reset asserted in the first dwell cycle of row 7.
    use16 = 1'b1; dwell_cycles = 16'd2; blank_cycles = 8'd1; continuous = 1'b0;
    pulse_start();
    push_rows(16, 0, 6, 1, 2);
    push_e(1'b0, 7, 1'b0, 1'b0, 1'b1);
    push_e(1'b1, 7, 1'b1, 1'b0, 1'b1);
    push_idle(3);
    set_flag(22, 2);
    drain("rst_mid");

    pulse_start();
    push_rows(16, 0, 15, 1, 2); push_idle(1);
    drain("rst_restart");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/row_scan_ctrl.md
Name: row_scan_ctrl

Overview:
- Sequencer that drives the enable and 4-bit select inputs of the 4-to-16 one-hot decoder, stepping it through rows 0..NUM_ROWS-1.
- Each row is one scan step, used for LED or keypad matrix scanning.
- Each row gets a programmable blanking gap with enable low, then a programmable dwell with enable high.
- Supports single-frame and continuous modes, and a graceful stop at the next row boundary.

Parameters:
NUM_ROWS, 16, rows scanned per frame (legal 2..16)
DWELL_W, 16, width of dwell_cycles

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous reset, active-low
start  in  1  pulse; begins a frame when idle
stop  in  1  pulse; request to end scanning at next row boundary
continuous  in  1  1 = restart at row 0 after last row; sampled at start
dwell_cycles  in  DWELL_W  cycles enable_out is high per row; latched at start
blank_cycles  in  8  cycles enable_out is low before each row; latched at start
enable_out  out  1  decoder enable
binary_out  out  4  decoder select (current row index)
row_start  out  1  one-cycle pulse on first enabled cycle of each row
frame_done  out  1  one-cycle pulse on last enabled cycle of row NUM_ROWS-1
busy  out  1  high whenever not IDLE

Behaviour:
- Single clock clk. Reset is synchronous, active-low on rst_n: sampled only on the rising clk edge.
- Reset values: enable_out=0, binary_out=0, row_start=0, frame_done=0, busy=0, state=IDLE, stop_pending=0, latched config=0.
- All outputs are registered. Asserting rst_n low mid-frame forces reset values on the next edge, with no frame_done.
- States:
  - IDLE: busy=0, enable_out=0, binary_out=0.
  - BLANK: enable_out=0, binary_out=row.
  - DRIVE: enable_out=1, binary_out=row.
- Start from IDLE (cycle t):
  - Latch dwell_cycles, blank_cycles and continuous; row=0; go to BLANK.
  - If blank_cycles=0, go directly to DRIVE.
- Timing with B=blank_cycles, D=max(dwell_cycles,1):
  - enable_out is low for cycles t+1..t+B and high for t+B+1..t+B+D.
  - binary_out is stable from the first BLANK cycle to the last DRIVE cycle of a row.
- dwell_cycles=0 is treated as 1.
- End of DRIVE:
  - row<NUM_ROWS-1: row+1, go to BLANK (or DRIVE if B=0).
  - row=NUM_ROWS-1: assert frame_done. Then:
    - continuous=1 and no stop_pending: row=0, next frame, no idle cycle.
    - Otherwise: go to IDLE.
- start while busy is ignored. Config changes while busy are ignored.
- stop while busy sets stop_pending.
  - At the end of the current row's DRIVE, go to IDLE and clear stop_pending.
  - frame_done fires only if that row was NUM_ROWS-1.
- stop in IDLE is ignored. start and stop in the same IDLE cycle: start is taken, stop is ignored.
- Back-to-back rows: the last DRIVE cycle of row r is followed immediately by the first BLANK (or DRIVE) cycle of row r+1.
- Wrap: the row counter never exceeds NUM_ROWS-1. When NUM_ROWS<16, select codes NUM_ROWS..15 are never output.

Decomposition:
- Shared package scan_pkg:
  - state enum {IDLE, BLANK, DRIVE};
  - constant ROW_W=4;
  - constant BLANK_W=8.
- Sub-module scan_timer:
  - loadable down-counter, width a parameter;
  - inputs load and load_val; output expired when count reaches 1.
  - Used for both the blank and dwell phases, one instance reloaded per phase.
- FSM and row counter live in row_scan_ctrl.

Test Plan:
- Reset then single frame (NUM_ROWS=4, continuous=0, dwell=3, blank=2, start at t) -> binary_out walks 0,1,2,3. Each row shows 2 low cycles then 3 high. frame_done at t+20; busy falls at t+21. Exactly four row_start pulses.
- blank=0, dwell=0, NUM_ROWS=16 -> enable_out high continuously for 16 cycles, binary_out 0..15 one per cycle, frame_done coincides with row 15.
- Continuous mode, dwell=2, blank=1 -> after row 15 the next cycle is BLANK with row 0, no idle gap. Two frame_done pulses 48 cycles apart.
- stop pulsed during BLANK of row 5 (continuous=1) -> row 5 completes its DRIVE, then IDLE with binary_out=0. No frame_done. A later start begins at row 0.
- start pulsed while busy, plus dwell_cycles changed mid-frame -> no restart, and timing stays at the originally latched values.
- rst_n low during DRIVE of row 7 -> next edge gives all outputs 0 and IDLE. start after release produces a normal frame from row 0.
